ifu: RTL and testbench

Instruction fetch unit: holds the architectural PC, issues one instruction-memory read at a time over a valid/ready request channel with variable-latency response, and presents the fetched instruction plus its PC to the decode stage under a valid/ready handshake. It sits directly upstream of decode. It applies next-PC selection (sequential +4 or redirect target from execute) on each decode handshake.

---
 rtl/ifu.sv | 98 +++++++++
 tb/tb_ifu.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, single-outstanding memory fetch, decode handoff
module ifu #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  output logic                  o_ifu_ram_req_valid,
  input  logic                  i_ifu_ram_req_ready,
  output logic [ADDR_WIDTH-1:0] o_ifu_ram_req_addr,
  input  logic                  i_ifu_ram_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_ifu_ram_rsp_inst,
  output logic                  o_sys_valid,
  input  logic                  i_sys_ready,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc,
  output logic [INST_WIDTH-1:0] o_ifu_inst,
  input  logic                  i_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_jmp_pc
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [INST_WIDTH-1:0] r_inst;

  // Word-aligned versions of the redirect target and the sequential successor.
  logic [ADDR_WIDTH-1:0] jmp_aligned;
  logic [ADDR_WIDTH-1:0] pc_seq;
  logic                  decode_fire;

  assign jmp_aligned = i_jmp_pc & ~ADDR_WIDTH'(3);
  assign pc_seq      = r_pc + ADDR_WIDTH'(4);
  assign decode_fire = (r_state == S_HOLD) && i_sys_ready;

  // State, PC and instruction registers; reset discards any in-flight fetch.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state <= S_RST;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
    end else begin
      r_state <= next_state;
      if ((r_state == S_WAIT) && i_ifu_ram_rsp_valid) begin
        r_inst <= i_ifu_ram_rsp_inst;
      end
      if (decode_fire) begin
        r_pc <= i_jmp_en ? jmp_aligned : pc_seq;
      end
    end
  end

  // Next-state selection and per-state output drive.
  always_comb begin
    next_state          = r_state;
    o_ifu_ram_req_valid = 1'b0;
    o_sys_valid         = 1'b0;
    o_ifu_pc            = '0;
    o_ifu_inst          = '0;
    case (r_state)
      S_RST: begin
        next_state = S_REQ;
      end
      S_REQ: begin
        o_ifu_ram_req_valid = 1'b1;
        if (i_ifu_ram_req_ready) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_ifu_ram_rsp_valid) begin
          next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        o_sys_valid = 1'b1;
        o_ifu_pc    = r_pc;
        o_ifu_inst  = r_inst;
        if (i_sys_ready) begin
          next_state = S_REQ;
        end
      end
      default: begin
        next_state = S_RST;
      end
    endcase
  end

  assign o_ifu_ram_req_addr = r_pc;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu with directed scenarios and a randomized reference model
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic        sys_valid;
  logic        sys_ready;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        jmp_en;
  logic [31:0] jmp_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  ifu dut (
    .i_sys_clk          (clk),
    .i_sys_rst          (rst),
    .o_ifu_ram_req_valid(req_valid),
    .i_ifu_ram_req_ready(req_ready),
    .o_ifu_ram_req_addr (req_addr),
    .i_ifu_ram_rsp_valid(rsp_valid),
    .i_ifu_ram_rsp_inst (rsp_inst),
    .o_sys_valid        (sys_valid),
    .i_sys_ready        (sys_ready),
    .o_ifu_pc           (ifu_pc),
    .o_ifu_inst         (ifu_inst),
    .i_jmp_en           (jmp_en),
    .i_jmp_pc           (jmp_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (DUT in reset-idle state, reset released).
  task automatic reset_dut();
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_inst = '0;
    sys_ready = 1'b0; jmp_en = 1'b0; jmp_pc = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Feeds one instruction until the DUT presents it to decode (bounded).
  task automatic run_to_hold(input logic [31:0] inst);
    int n;
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_inst = inst; sys_ready = 1'b0;
    n = 0;
    while (!sys_valid && n < 10) begin
      step();
      n++;
    end
    req_ready = 1'b0; rsp_valid = 1'b0;
    if (!sys_valid) begin
      checks++; errors++;
      $display("FAIL hold_timeout: sys_valid=%0b required 1", sys_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b1; rsp_inst = 32'hDEAD_BEEF;
    sys_ready = 1'b1; jmp_en = 1'b0; jmp_pc = '0;
    step();
    step();
    checks++;
    if ({req_valid, sys_valid} !== 2'b00 || req_addr !== RST_PC || ifu_pc !== 0 || ifu_inst !== 0) begin
      errors++;
      $display("FAIL reset_during: valid=%b addr=%h pc=%h inst=%h required 00/%h/0/0",
               {req_valid, sys_valid}, req_addr, ifu_pc, ifu_inst, RST_PC);
    end
    rst = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; sys_ready = 1'b0;
    checks++;
    if ({req_valid, sys_valid} !== 2'b00 || req_addr !== RST_PC || ifu_pc !== 0 || ifu_inst !== 0) begin
      errors++;
      $display("FAIL reset_cycle0: valid=%b addr=%h pc=%h inst=%h", {req_valid, sys_valid}, req_addr, ifu_pc, ifu_inst);
    end
  endtask

  task automatic test_basic_fetch();
    reset_dut();
    req_ready = 1'b1;
    step();
    checks++;
    if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
      errors++;
      $display("FAIL basic_req_c1: valid=%b addr=%h required 1/%h", req_valid, req_addr, RST_PC);
    end
    rsp_valid = 1'b1; rsp_inst = 32'h0000_0013;
    step();
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || sys_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait_c2: req_valid=%b sys_valid=%b required 0/0", req_valid, sys_valid);
    end
    step();
    rsp_valid = 1'b0;
    checks++;
    if (sys_valid !== 1'b1 || ifu_pc !== RST_PC || ifu_inst !== 32'h13) begin
      errors++;
      $display("FAIL basic_hold_c3: valid=%b pc=%h inst=%h required 1/%h/00000013", sys_valid, ifu_pc, ifu_inst, RST_PC);
    end
    sys_ready = 1'b1;
    step();
    sys_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004 || sys_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_next_addr: valid=%b addr=%h sys_valid=%b required 1/80000004/0", req_valid, req_addr, sys_valid);
    end
  endtask

  task automatic test_req_stall();
    reset_dut();
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
        errors++;
        $display("FAIL req_stall[%0d]: valid=%b addr=%h required 1/%h", i, req_valid, req_addr, RST_PC);
      end
      step();
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || sys_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_accept: req_valid=%b sys_valid=%b required 0/0", req_valid, sys_valid);
    end
  endtask

  // Continues from the wait state left by test_req_stall.
  task automatic test_decode_stall();
    rsp_valid = 1'b1; rsp_inst = 32'h1234_5678;
    step();
    for (int i = 0; i < 5; i++) begin
      rsp_valid = i[0]; rsp_inst = $urandom;
      checks++;
      if (sys_valid !== 1'b1 || ifu_pc !== RST_PC || ifu_inst !== 32'h1234_5678 || req_valid !== 1'b0) begin
        errors++;
        $display("FAIL decode_stall[%0d]: valid=%b pc=%h inst=%h req_valid=%b required 1/%h/12345678/0",
                 i, sys_valid, ifu_pc, ifu_inst, req_valid, RST_PC);
      end
      step();
    end
    rsp_valid = 1'b0; sys_ready = 1'b1;
    step();
    sys_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004) begin
      errors++;
      $display("FAIL decode_release: valid=%b addr=%h required 1/80000004", req_valid, req_addr);
    end
  endtask

  task automatic test_jump();
    reset_dut();
    step();
    jmp_en = 1'b1; jmp_pc = 32'h0000_1234;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'h0000_006F;
    step();
    rsp_valid = 1'b0; jmp_en = 1'b0;
    checks++;
    if (sys_valid !== 1'b1 || ifu_pc !== RST_PC) begin
      errors++;
      $display("FAIL jump_ignored_in_wait: valid=%b pc=%h required 1/%h", sys_valid, ifu_pc, RST_PC);
    end
    jmp_en = 1'b1; jmp_pc = 32'h8000_0102; sys_ready = 1'b1;
    step();
    jmp_en = 1'b0; sys_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL jump_target: valid=%b addr=%h required 1/80000100", req_valid, req_addr);
    end
  endtask

  task automatic test_wrap();
    run_to_hold(32'h1111_1111);
    jmp_en = 1'b1; jmp_pc = 32'hFFFF_FFFF; sys_ready = 1'b1;
    step();
    jmp_en = 1'b0; sys_ready = 1'b0;
    checks++;
    if (req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_setup: addr=%h required fffffffc", req_addr);
    end
    run_to_hold(32'h2222_2222);
    checks++;
    if (ifu_pc !== 32'hFFFF_FFFC || ifu_inst !== 32'h2222_2222) begin
      errors++;
      $display("FAIL wrap_hold: pc=%h inst=%h required fffffffc/22222222", ifu_pc, ifu_inst);
    end
    sys_ready = 1'b1;
    step();
    sys_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_next: valid=%b addr=%h required 1/00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    reset_dut();
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; rsp_valid = 1'b1; rsp_inst = 32'hBAD0_BAD0;
    checks++;
    if (sys_valid !== 1'b0 || req_valid !== 1'b0 || req_addr !== RST_PC) begin
      errors++;
      $display("FAIL rst_wait_idle: sys_valid=%b req_valid=%b addr=%h required 0/0/%h", sys_valid, req_valid, req_addr, RST_PC);
    end
    step();
    checks++;
    if (sys_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== RST_PC) begin
      errors++;
      $display("FAIL rst_wait_fresh_req: sys_valid=%b req_valid=%b addr=%h required 0/1/%h", sys_valid, req_valid, req_addr, RST_PC);
    end
    step();
    rsp_valid = 1'b0;
    checks++;
    if (sys_valid !== 1'b0 || req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_late_rsp: sys_valid=%b req_valid=%b required 0/1", sys_valid, req_valid);
    end
    run_to_hold(32'h0000_0013);
    checks++;
    if (ifu_pc !== RST_PC || ifu_inst !== 32'h0000_0013) begin
      errors++;
      $display("FAIL rst_wait_refetch: pc=%h inst=%h required %h/00000013", ifu_pc, ifu_inst, RST_PC);
    end
  endtask

  // Random memory latency, back-pressure and redirects against a PC-sequence model.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] out_addr;
    logic        outstanding;
    int          delay;
    int          delivered;
    reset_dut();
    exp_pc = RST_PC; outstanding = 1'b0; delay = 0; delivered = 0; out_addr = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      checks++;
      if (req_valid && sys_valid) begin
        errors++;
        $display("FAIL rnd_exclusive[%0d]: req_valid=%b sys_valid=%b", cyc, req_valid, sys_valid);
      end
      rsp_valid = 1'b0; rsp_inst = $urandom;
      if (outstanding) begin
        if (delay == 0) begin
          rsp_valid = 1'b1; rsp_inst = inst_of(out_addr); outstanding = 1'b0;
        end else begin
          delay--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rsp_valid = 1'b1;
      end
      req_ready = 1'b0;
      if (req_valid) begin
        checks++;
        if (req_addr !== exp_pc || outstanding) begin
          errors++;
          $display("FAIL rnd_req[%0d]: addr=%h outstanding=%b required %h/0", cyc, req_addr, outstanding, exp_pc);
        end
        req_ready = $urandom_range(0, 1);
        if (req_ready) begin
          outstanding = 1'b1; out_addr = exp_pc; delay = $urandom_range(0, 2);
        end
      end
      sys_ready = $urandom_range(0, 1);
      jmp_en = ($urandom_range(0, 3) == 0);
      jmp_pc = $urandom;
      if (sys_valid) begin
        checks++;
        if (ifu_pc !== exp_pc || ifu_inst !== inst_of(exp_pc)) begin
          errors++;
          $display("FAIL rnd_deliver[%0d]: pc=%h inst=%h required %h/%h", cyc, ifu_pc, ifu_inst, exp_pc, inst_of(exp_pc));
        end
        if (sys_ready) begin
          exp_pc = jmp_en ? {jmp_pc[31:2], 2'b00} : exp_pc + 32'd4;
          delivered++;
        end
      end else begin
        checks++;
        if (ifu_pc !== 0 || ifu_inst !== 0) begin
          errors++;
          $display("FAIL rnd_idle_out[%0d]: pc=%h inst=%h required 0/0", cyc, ifu_pc, ifu_inst);
        end
      end
      step();
    end
    req_ready = 1'b0; rsp_valid = 1'b0; sys_ready = 1'b0; jmp_en = 1'b0;
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rnd_progress: delivered=%0d required at least 100", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_req_stall();
    test_decode_stall();
    test_jump();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
